// File: rtl/adc_block_averager.sv
// adc_block_averager
// Conditioning stage for the SPGD loop. After each START it throws away a
// programmable number of settling samples, sums 2^L raw ADC codes, and then
// presents the exact sum and the round-half-up mean with a one-cycle VALID.
// Everything runs in the ADC clock domain.

module adc_block_averager #(
  parameter int ADC_WIDTH    = 12,
  parameter int MAX_LOG2     = 14,
  parameter int SETTLE_WIDTH = 16
) (
  input  logic                          ADC_CLK,
  input  logic                          RST,
  input  logic [ADC_WIDTH-1:0]          ADC_DATA_IN,
  input  logic                          START,
  input  logic [3:0]                    LOG2_N,
  input  logic [SETTLE_WIDTH-1:0]       SETTLE_CYCLES,
  output logic                          BUSY,
  output logic                          VALID,
  output logic [ADC_WIDTH-1:0]          AVE_OUT,
  output logic [ADC_WIDTH+MAX_LOG2-1:0] SUM_OUT
);

  // The accumulator is wide enough to hold 2^MAX_LOG2 full-scale codes, so
  // it can never wrap.
  localparam int SUM_W = ADC_WIDTH + MAX_LOG2;

  // One shared counter serves both the settle phase and the sample phase,
  // so it has to cover the larger of the two ranges.
  localparam int CNT_W = (SETTLE_WIDTH > MAX_LOG2 + 1) ? SETTLE_WIDTH : MAX_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCUM,
    OUTPUT
  } state_t;

  state_t                  state;
  state_t                  state_next;

  logic [3:0]              l_eff;
  logic [SETTLE_WIDTH-1:0] settle_len;
  logic [CNT_W-1:0]        counter;
  logic [SUM_W-1:0]        accum;

  logic [3:0]              l_eff_start;
  logic                    settle_done;
  logic                    accum_done;
  logic [SUM_W-1:0]        round_term;
  logic [ADC_WIDTH-1:0]    ave_next;

  // A LOG2_N above the supported maximum is clamped rather than rejected.
  always_comb begin
    l_eff_start = LOG2_N;
    if (LOG2_N > 4'(MAX_LOG2)) begin
      l_eff_start = 4'(MAX_LOG2);
    end
  end

  // Terminal-count decodes for the settle and sample phases, and the rounded
  // mean. When L is zero the mean is the single sample, so no rounding term
  // is added.
  always_comb begin
    settle_done = (counter == (CNT_W'(settle_len) - CNT_W'(1)));
    accum_done  = (counter == ((CNT_W'(1) << l_eff) - CNT_W'(1)));
    round_term  = '0;
    if (l_eff != 4'd0) begin
      round_term = SUM_W'(1) << (l_eff - 4'd1);
    end
    ave_next = ADC_WIDTH'((accum + round_term) >> l_eff);
  end

  // State register.
  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. START is only looked at in IDLE, so a START during a
  // block is dropped rather than queued. A zero settle count skips SETTLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (START) begin
          if (SETTLE_CYCLES != '0) begin
            state_next = SETTLE;
          end else begin
            state_next = ACCUM;
          end
        end
      end
      SETTLE: begin
        if (settle_done) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (accum_done) begin
          state_next = OUTPUT;
        end
      end
      OUTPUT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. Block parameters are captured at START so that later changes
  // on LOG2_N or SETTLE_CYCLES cannot disturb a block already running. The
  // outputs hold between blocks and change only on the OUTPUT exit edge.
  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      l_eff      <= '0;
      settle_len <= '0;
      counter    <= '0;
      accum      <= '0;
      VALID      <= 1'b0;
      AVE_OUT    <= '0;
      SUM_OUT    <= '0;
    end else begin
      VALID <= (state == OUTPUT);
      case (state)
        IDLE: begin
          if (START) begin
            l_eff      <= l_eff_start;
            settle_len <= SETTLE_CYCLES;
            counter    <= '0;
            accum      <= '0;
          end
        end
        SETTLE: begin
          if (settle_done) begin
            counter <= '0;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        ACCUM: begin
          accum   <= accum + SUM_W'(ADC_DATA_IN);
          counter <= counter + CNT_W'(1);
        end
        OUTPUT: begin
          SUM_OUT <= accum;
          AVE_OUT <= ave_next;
        end
        default: begin
          counter <= '0;
        end
      endcase
    end
  end

  // BUSY covers every state except IDLE, so it drops in the VALID cycle.
  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_adc_block_averager.sv
// Testbench for adc_block_averager: table of directed blocks with
// hand-computed sums, means and latencies, plus hand-written sequences for
// mid-block START, back-to-back blocks and mid-block reset.

module tb_adc_block_averager;

  logic        adc_clk;
  logic        rst;
  logic [11:0] adc_data_in;
  logic        start;
  logic [3:0]  log2_n;
  logic [15:0] settle_cycles;
  logic        busy;
  logic        valid;
  logic [11:0] ave_out;
  logic [25:0] sum_out;

  int tests_run;
  int tests_failed;

  adc_block_averager #(
    .ADC_WIDTH   (12),
    .MAX_LOG2    (14),
    .SETTLE_WIDTH(16)
  ) dut (
    .ADC_CLK      (adc_clk),
    .RST          (rst),
    .ADC_DATA_IN  (adc_data_in),
    .START        (start),
    .LOG2_N       (log2_n),
    .SETTLE_CYCLES(settle_cycles),
    .BUSY         (busy),
    .VALID        (valid),
    .AVE_OUT      (ave_out),
    .SUM_OUT      (sum_out)
  );

  // 10-unit ADC clock.
  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  // One directed block. Sample m (m >= 1 counts edges after the START edge)
  // is settle_val while m <= settle, otherwise base + step * (m - settle - 1).
  // exp_latency is the number of edges after the START edge until VALID is
  // seen, i.e. S + N + 1.
  typedef struct {
    int          log2_n;
    int          settle;
    int          settle_val;
    int          base;
    int          step;
    logic [25:0] exp_sum;
    logic [11:0] exp_ave;
    int          exp_latency;
  } vec_t;

  vec_t vecs [9];

  task automatic check_value(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one block and reports what was observed. After the START edge the
  // block inputs are scrambled to show they were latched.
  task automatic applyStimulus(input vec_t v, output int latency,
                               output logic [25:0] sum_seen, output logic [11:0] ave_seen,
                               output logic busy_at_valid, output logic valid_after,
                               output int busy_bad);
    int cnt;
    int m;
    latency       = -1;
    sum_seen      = '0;
    ave_seen      = '0;
    busy_at_valid = 1'b1;
    valid_after   = 1'b1;
    busy_bad      = 0;
    @(negedge adc_clk);
    start         = 1'b1;
    log2_n        = 4'(v.log2_n);
    settle_cycles = 16'(v.settle);
    adc_data_in   = 12'h0;
    @(posedge adc_clk);
    cnt = 0;
    while (cnt < 20000) begin
      @(negedge adc_clk);
      start         = 1'b0;
      log2_n        = 4'd1;
      settle_cycles = 16'd7;
      if (valid) begin
        latency       = cnt;
        sum_seen      = sum_out;
        ave_seen      = ave_out;
        busy_at_valid = busy;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      m = cnt + 1;
      if (m <= v.settle) adc_data_in = 12'(v.settle_val);
      else adc_data_in = 12'(v.base + v.step * (m - v.settle - 1));
      @(posedge adc_clk);
      cnt++;
    end
    if (latency >= 0) begin
      @(negedge adc_clk);
      valid_after = valid;
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t v, input int latency,
                             input logic [25:0] sum_seen, input logic [11:0] ave_seen,
                             input logic busy_at_valid, input logic valid_after,
                             input int busy_bad);
    check_value({tag, " latency"}, 64'(latency), 64'(v.exp_latency));
    check_value({tag, " sum"}, 64'(sum_seen), 64'(v.exp_sum));
    check_value({tag, " ave"}, 64'(ave_seen), 64'(v.exp_ave));
    check_value({tag, " busy_in_valid_cycle"}, 64'(busy_at_valid), 64'(0));
    check_value({tag, " valid_single_cycle"}, 64'(valid_after), 64'(0));
    check_value({tag, " busy_low_during_block"}, 64'(busy_bad), 64'(0));
  endtask

  initial begin
    int          lat;
    logic [25:0] s;
    logic [11:0] a;
    logic        bv;
    logic        va;
    int          bb;
    int          nvalid;
    int          first_valid;
    int          vt [3];

    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{10, 0, 0,    'h800, 0, 26'h200000,  12'h800, 1025};
    vecs[1] = '{4,  0, 0,    0,     1, 26'd120,     12'd8,   17};
    vecs[2] = '{4,  0, 0,    1,     1, 26'd136,     12'd9,   17};
    vecs[3] = '{14, 0, 0,    'hFFF, 0, 26'h3FFC000, 12'hFFF, 16385};
    vecs[4] = '{15, 0, 0,    'hFFF, 0, 26'h3FFC000, 12'hFFF, 16385};
    vecs[5] = '{2,  5, 100,  4,     4, 26'd40,      12'd10,  10};
    vecs[6] = '{0,  0, 0,    'h5A3, 7, 26'h5A3,     12'h5A3, 2};
    vecs[7] = '{2,  0, 0,    1,     1, 26'd10,      12'd3,   5};
    vecs[8] = '{1,  3, 'hFFF, 5,    1, 26'd11,      12'd6,   6};

    rst           = 1'b1;
    start         = 1'b0;
    log2_n        = 4'd0;
    settle_cycles = 16'd0;
    adc_data_in   = 12'h0;
    #1;
    check_value("reset busy", 64'(busy), 64'(0));
    check_value("reset valid", 64'(valid), 64'(0));
    check_value("reset ave", 64'(ave_out), 64'(0));
    check_value("reset sum", 64'(sum_out), 64'(0));
    @(negedge adc_clk);
    @(negedge adc_clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], lat, s, a, bv, va, bb);
      checkOutput($sformatf("vec%0d", i), vecs[i], lat, s, a, bv, va, bb);
    end

    // START pulsed mid-ACCUM must be ignored: one VALID, edge 9, sum 8*10.
    @(negedge adc_clk);
    start = 1'b1; log2_n = 4'd3; settle_cycles = 16'd0; adc_data_in = 12'd10;
    @(posedge adc_clk);
    nvalid = 0; first_valid = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge adc_clk);
      start = (c == 4);
      if (valid) begin
        nvalid++;
        if (first_valid < 0) first_valid = c;
      end
      @(posedge adc_clk);
    end
    @(negedge adc_clk);
    start = 1'b0;
    check_value("midstart valid_count", 64'(nvalid), 64'(1));
    check_value("midstart valid_edge", 64'(first_valid), 64'(9));
    check_value("midstart sum", 64'(sum_out), 64'(80));
    check_value("midstart ave", 64'(ave_out), 64'(10));

    // START held high: three blocks, VALIDs 10 cycles apart, sum 8*20.
    @(negedge adc_clk);
    start = 1'b1; log2_n = 4'd3; settle_cycles = 16'd0; adc_data_in = 12'd20;
    @(posedge adc_clk);
    nvalid = 0;
    vt[0] = -100; vt[1] = -100; vt[2] = -100;
    for (int c = 0; c < 50; c++) begin
      @(negedge adc_clk);
      if (valid) begin
        if (nvalid < 3) vt[nvalid] = c;
        nvalid++;
        if (nvalid == 3) start = 1'b0;
      end
      @(posedge adc_clk);
    end
    @(negedge adc_clk);
    check_value("b2b valid_count", 64'(nvalid), 64'(3));
    check_value("b2b first_valid_edge", 64'(vt[0]), 64'(9));
    check_value("b2b gap1", 64'(vt[1] - vt[0]), 64'(10));
    check_value("b2b gap2", 64'(vt[2] - vt[1]), 64'(10));
    check_value("b2b sum", 64'(sum_out), 64'(160));
    check_value("b2b busy_after", 64'(busy), 64'(0));

    // Reset mid-ACCUM clears everything at once and the block never reports.
    @(negedge adc_clk);
    start = 1'b1; log2_n = 4'd4; settle_cycles = 16'd0; adc_data_in = 12'hABC;
    @(posedge adc_clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge adc_clk);
      start = 1'b0;
      @(posedge adc_clk);
    end
    @(negedge adc_clk);
    rst = 1'b1;
    #1;
    check_value("midreset busy", 64'(busy), 64'(0));
    check_value("midreset valid", 64'(valid), 64'(0));
    check_value("midreset ave", 64'(ave_out), 64'(0));
    check_value("midreset sum", 64'(sum_out), 64'(0));
    @(negedge adc_clk);
    rst = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge adc_clk);
      if (valid || busy) nvalid++;
    end
    check_value("midreset no_activity", 64'(nvalid), 64'(0));

    // Fresh block after reset carries no residue from the abandoned one.
    applyStimulus(vecs[7], lat, s, a, bv, va, bb);
    checkOutput("postreset", vecs[7], lat, s, a, bv, va, bb);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
